// File: rtl/ula_controle_multiciclo_pkg.sv
// Shared ULA/MIPS constants and control-FSM state encoding.
// Used by the multicycle control and by the funct -> ULA OP decoder.
package ula_pkg;

   localparam logic [3:0] ULA_AND  = 4'b0000;
   localparam logic [3:0] ULA_OR   = 4'b0001;
   localparam logic [3:0] ULA_ADD  = 4'b0010;
   localparam logic [3:0] ULA_XOR  = 4'b0011;
   localparam logic [3:0] ULA_ADDU = 4'b0100;
   localparam logic [3:0] ULA_SUBU = 4'b0101;
   localparam logic [3:0] ULA_SUB  = 4'b0110;
   localparam logic [3:0] ULA_SLT  = 4'b0111;
   localparam logic [3:0] ULA_SLTU = 4'b1000;
   localparam logic [3:0] ULA_NOR  = 4'b1100;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_RTYPE   = 4'd2,
      S_RWB     = 4'd3,
      S_MEMADR  = 4'd4,
      S_MEMRD   = 4'd5,
      S_MEMWB   = 4'd6,
      S_MEMWR   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDI_EX = 4'd9,
      S_ADDI_WB = 4'd10,
      S_JUMP    = 4'd11,
      S_ILLEGAL = 4'd12
   } state_t;

   // States that hold on the unified memory port until mem_ready.
   function automatic logic is_mem_wait(state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/ula_controle_multiciclo_if.sv
// Control <-> datapath/memory bundle; master = control FSM, slave = datapath side.
interface ula_controle_multiciclo_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic [3:0] ula_op;
   logic       ula_src_a;
   logic [1:0] ula_src_b;
   logic [1:0] pc_src;
   logic       pc_we;
   logic       iord;
   logic       mem_rd;
   logic       mem_we;
   logic       ir_we;
   logic       reg_we;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       illegal;
   logic       mem_err;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output ula_op, ula_src_a, ula_src_b, pc_src, pc_we, iord, mem_rd, mem_we,
             ir_we, reg_we, reg_dst, mem_to_reg, illegal, mem_err
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  ula_op, ula_src_a, ula_src_b, pc_src, pc_we, iord, mem_rd, mem_we,
             ir_we, reg_we, reg_dst, mem_to_reg, illegal, mem_err
   );
endinterface

// File: rtl/ula_controle_multiciclo_ula_op_decoder.sv
// Combinational R-type funct -> ULA OP decode with a supported-funct flag.
// Zero latency; no flow control.
module ula_op_decoder
   import ula_pkg::*;
(
   input  logic [5:0] i_funct,
   output logic [3:0] o_ula_op,
   output logic       o_valid
);

   always_comb begin
      o_ula_op = ULA_ADD;
      o_valid  = 1'b1;
      case (i_funct)
         F_ADD:   o_ula_op = ULA_ADD;
         F_ADDU:  o_ula_op = ULA_ADDU;
         F_SUB:   o_ula_op = ULA_SUB;
         F_SUBU:  o_ula_op = ULA_SUBU;
         F_AND:   o_ula_op = ULA_AND;
         F_OR:    o_ula_op = ULA_OR;
         F_XOR:   o_ula_op = ULA_XOR;
         F_NOR:   o_ula_op = ULA_NOR;
         F_SLT:   o_ula_op = ULA_SLT;
         F_SLTU:  o_ula_op = ULA_SLTU;
         default: o_valid  = 1'b0;
      endcase
   end

endmodule

// File: rtl/ula_controle_multiciclo.sv
// Multicycle MIPS control FSM: 3-5 cycles per instruction plus one per memory wait state;
// FETCH/MEMRD/MEMWR hold on mem_ready and give up after MEM_TIMEOUT waiting cycles.
module ula_controle_multiciclo
   import ula_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
)(
   input  logic                        clk,
   input  logic                        rst_n,
   ula_controle_multiciclo_if.master   bus
);

   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [5:0]       r_opcode;
   logic [3:0]       r_rtype_op;

   logic [3:0]       w_dec_op;
   logic             w_dec_vld;
   logic             w_waiting;
   logic             w_timeout;

   ula_op_decoder u_dec (
      .i_funct  (bus.funct),
      .o_ula_op (w_dec_op),
      .o_valid  (w_dec_vld)
   );

   assign w_waiting = is_mem_wait(r_state) && !bus.mem_ready;
   assign w_timeout = w_waiting && (r_wait_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_FETCH;
         r_wait_cnt <= '0;
         r_opcode   <= '0;
         r_rtype_op <= ULA_AND;
      end else begin
         // Counter only runs while stalled; any progress or a timeout restarts it.
         if (!w_waiting || w_timeout)
            r_wait_cnt <= '0;
         else
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);

         case (r_state)
            S_FETCH: begin
               if (bus.mem_ready)
                  r_state <= S_DECODE;
            end
            S_DECODE: begin
               r_opcode   <= bus.opcode;
               r_rtype_op <= w_dec_op;
               case (bus.opcode)
                  OP_RTYPE: r_state <= w_dec_vld ? S_RTYPE : S_ILLEGAL;
                  OP_LW,
                  OP_SW:    r_state <= S_MEMADR;
                  OP_BEQ,
                  OP_BNE:   r_state <= S_BRANCH;
                  OP_ADDI:  r_state <= S_ADDI_EX;
                  OP_J:     r_state <= S_JUMP;
                  default:  r_state <= S_ILLEGAL;
               endcase
            end
            S_RTYPE:   r_state <= S_RWB;
            S_MEMADR:  r_state <= (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
               if (bus.mem_ready)
                  r_state <= S_MEMWB;
               else if (w_timeout)
                  r_state <= S_FETCH;
            end
            S_MEMWR: begin
               if (bus.mem_ready || w_timeout)
                  r_state <= S_FETCH;
            end
            S_ADDI_EX: r_state <= S_ADDI_WB;
            default:   r_state <= S_FETCH;
         endcase
      end
   end

   // Outputs decode straight from state so they are valid in the first cycle after reset.
   always_comb begin
      bus.ula_op     = ULA_AND;
      bus.ula_src_a  = 1'b0;
      bus.ula_src_b  = 2'd0;
      bus.pc_src     = 2'd0;
      bus.pc_we      = 1'b0;
      bus.iord       = 1'b0;
      bus.mem_rd     = 1'b0;
      bus.mem_we     = 1'b0;
      bus.ir_we      = 1'b0;
      bus.reg_we     = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.illegal    = 1'b0;
      bus.mem_err    = w_timeout && rst_n;
      if (rst_n) begin
         case (r_state)
            S_FETCH: begin
               bus.ula_src_b = 2'd1;
               bus.ula_op    = ULA_ADD;
               bus.mem_rd    = !w_timeout;
               bus.ir_we     = bus.mem_ready;
               bus.pc_we     = bus.mem_ready;
            end
            S_DECODE: begin
               bus.ula_src_b = 2'd3;
               bus.ula_op    = ULA_ADD;
            end
            S_RTYPE: begin
               bus.ula_src_a = 1'b1;
               bus.ula_op    = r_rtype_op;
            end
            S_RWB: begin
               bus.reg_we  = 1'b1;
               bus.reg_dst = 1'b1;
            end
            S_MEMADR, S_ADDI_EX: begin
               bus.ula_src_a = 1'b1;
               bus.ula_src_b = 2'd2;
               bus.ula_op    = ULA_ADD;
            end
            S_MEMRD: begin
               bus.iord   = 1'b1;
               bus.mem_rd = !w_timeout;
            end
            S_MEMWB: begin
               bus.reg_we     = 1'b1;
               bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
               bus.iord   = 1'b1;
               bus.mem_we = !w_timeout;
            end
            S_BRANCH: begin
               bus.ula_src_a = 1'b1;
               bus.ula_op    = ULA_SUB;
               bus.pc_src    = 2'd1;
               bus.pc_we     = (r_opcode == OP_BEQ) ? bus.zero : !bus.zero;
            end
            S_ADDI_WB: begin
               bus.reg_we = 1'b1;
            end
            S_JUMP: begin
               bus.pc_src = 2'd2;
               bus.pc_we  = 1'b1;
            end
            S_ILLEGAL: begin
               bus.illegal = 1'b1;
            end
            default: begin
               bus.illegal = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ula_controle_multiciclo.sv
// Directed + randomized instruction sequences checked cycle by cycle against an
// instruction-level model of the control outputs.
module tb_ula_controle_multiciclo;

   localparam int TMO = 15;

   localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                          BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                          JMP = 6'b000010;

   typedef struct packed {
      logic [3:0] op;
      logic       sa;
      logic [1:0] sb;
      logic [1:0] ps;
      logic       pc_we, iord, mem_rd, mem_we, ir_we, reg_we, rdst, m2r, ill, merr;
   } out_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [3:0] rop [logic [5:0]];

   always #5 clk = ~clk;

   ula_controle_multiciclo_if bus ();

   ula_controle_multiciclo #(.MEM_TIMEOUT(TMO)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic out_t obs();
      out_t o;
      o.op = bus.ula_op;   o.sa = bus.ula_src_a; o.sb = bus.ula_src_b; o.ps = bus.pc_src;
      o.pc_we = bus.pc_we; o.iord = bus.iord;    o.mem_rd = bus.mem_rd; o.mem_we = bus.mem_we;
      o.ir_we = bus.ir_we; o.reg_we = bus.reg_we; o.rdst = bus.reg_dst; o.m2r = bus.mem_to_reg;
      o.ill = bus.illegal; o.merr = bus.mem_err;
      return o;
   endfunction

   // Enables and pulses are checked every cycle; selects only where they matter.
   function automatic out_t en_mask();
      out_t m;
      m = '0;
      m.pc_we = 1'b1; m.mem_rd = 1'b1; m.mem_we = 1'b1; m.ir_we = 1'b1;
      m.reg_we = 1'b1; m.ill = 1'b1; m.merr = 1'b1;
      return m;
   endfunction

   task automatic chk(input string tag, input out_t e, input out_t m);
      out_t o;
      o = obs();
      n_cmp++;
      assert ((o & m) === (e & m)) else begin
         n_bad++;
         $error("FAIL %s: observed %h required %h (mask %h)", tag, o, e, m);
      end
   endtask

   task automatic step(input string tag, input out_t e, input out_t m);
      @(negedge clk);
      chk(tag, e, m);
      @(posedge clk);
      #1;
   endtask

   task automatic mem_phase(input string tag, input out_t ew, input out_t er,
                            input out_t m, input int w, output bit tmo);
      out_t et;
      tmo = 1'b0;
      for (int i = 0; i <= w; i++) begin
         if (i == TMO - 1 && i < w) begin
            bus.mem_ready = 1'b0;
            et = '0;
            et.merr = 1'b1;
            step({tag, "_timeout"}, et, en_mask());
            tmo = 1'b1;
            return;
         end
         bus.mem_ready = (i == w);
         if (i == w) step({tag, "_ready"}, er, m);
         else        step({tag, "_wait"}, ew, m);
      end
   endtask

   // One instruction: fw/mw = mem_ready-low cycles in fetch / data phase (>= TMO times out).
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw);
      out_t e, er, m;
      bit   tmo;
      bus.opcode = op; bus.funct = fn; bus.zero = z;

      e = '0; e.op = 4'b0010; e.sb = 2'd1; e.mem_rd = 1'b1;
      er = e; er.ir_we = 1'b1; er.pc_we = 1'b1;
      m = en_mask(); m.op = '1; m.sa = 1'b1; m.sb = '1; m.iord = 1'b1;
      mem_phase("fetch", e, er, m, fw, tmo);
      if (tmo) mem_phase("refetch", e, er, m, 0, tmo);

      bus.mem_ready = 1'($urandom);
      e = '0; e.op = 4'b0010; e.sb = 2'd3;
      m = en_mask(); m.op = '1; m.sa = 1'b1; m.sb = '1;
      step("decode", e, m);
      bus.opcode = 6'($urandom);
      bus.funct  = 6'($urandom);
      bus.mem_ready = 1'($urandom);

      e = '0; m = en_mask();
      if (op == RT && rop.exists(fn)) begin
         e.sa = 1'b1; e.op = rop[fn]; m.op = '1; m.sa = 1'b1; m.sb = '1;
         step("rtype", e, m);
         e = '0; e.reg_we = 1'b1; e.rdst = 1'b1; m = en_mask(); m.rdst = 1'b1; m.m2r = 1'b1;
         step("rwb", e, m);
      end else if (op == LW || op == SW) begin
         e.sa = 1'b1; e.sb = 2'd2; e.op = 4'b0010; m.op = '1; m.sa = 1'b1; m.sb = '1;
         step("memadr", e, m);
         e = '0; e.iord = 1'b1;
         if (op == LW) e.mem_rd = 1'b1; else e.mem_we = 1'b1;
         m = en_mask(); m.iord = 1'b1;
         mem_phase((op == LW) ? "memrd" : "memwr", e, e, m, mw, tmo);
         if (op == LW && !tmo) begin
            bus.mem_ready = 1'($urandom);
            e = '0; e.reg_we = 1'b1; e.m2r = 1'b1; m = en_mask(); m.rdst = 1'b1; m.m2r = 1'b1;
            step("memwb", e, m);
         end
      end else if (op == BEQ || op == BNE) begin
         e.sa = 1'b1; e.op = 4'b0110; e.ps = 2'd1;
         e.pc_we = (op == BEQ) ? z : !z;
         m.op = '1; m.sa = 1'b1; m.sb = '1; m.ps = '1;
         step("branch", e, m);
      end else if (op == ADDI) begin
         e.sa = 1'b1; e.sb = 2'd2; e.op = 4'b0010; m.op = '1; m.sa = 1'b1; m.sb = '1;
         step("addi_ex", e, m);
         e = '0; e.reg_we = 1'b1; m = en_mask(); m.rdst = 1'b1; m.m2r = 1'b1;
         step("addi_wb", e, m);
      end else if (op == JMP) begin
         e.ps = 2'd2; e.pc_we = 1'b1; m.ps = '1;
         step("jump", e, m);
      end else begin
         e.ill = 1'b1;
         step("illegal", e, m);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish within time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      out_t e, m;
      logic [5:0] op_tab [8];
      logic [5:0] fn;
      logic [5:0] valid_fn [10];

      rop[6'b100000] = 4'b0010; rop[6'b100001] = 4'b0100; rop[6'b100010] = 4'b0110;
      rop[6'b100011] = 4'b0101; rop[6'b100100] = 4'b0000; rop[6'b100101] = 4'b0001;
      rop[6'b100110] = 4'b0011; rop[6'b100111] = 4'b1100; rop[6'b101010] = 4'b0111;
      rop[6'b101011] = 4'b1000;
      valid_fn = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                   6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011};
      op_tab = '{RT, LW, SW, BEQ, BNE, ADDI, JMP, 6'b111111};

      bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      step("reset_hold", '0, '1);
      rst_n = 1'b1;

      run_instr(RT, 6'b100011, 1'b0, 0, 0);          // SUBU straight out of reset
      run_instr(BEQ, 6'h15, 1'b1, 0, 0);
      run_instr(BNE, 6'h2a, 1'b1, 0, 0);
      run_instr(BEQ, 6'h00, 1'b0, 1, 0);
      run_instr(LW, 6'h00, 1'b0, 0, 3);
      run_instr(ADDI, 6'h00, 1'b0, TMO, 0);          // fetch timeout then retry
      run_instr(6'b111111, 6'h00, 1'b0, 0, 0);
      run_instr(RT, 6'b000000, 1'b0, 0, 0);          // unsupported funct
      run_instr(LW, 6'h00, 1'b0, 0, TMO);            // data-read timeout
      run_instr(SW, 6'h00, 1'b0, 2, 14);             // last wait before timeout
      run_instr(JMP, 6'h00, 1'b0, 0, 0);

      // Reset pulled in the middle of a store.
      bus.opcode = SW; bus.mem_ready = 1'b1;
      e = '0; e.mem_rd = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
      step("sw_fetch", e, en_mask());
      e = '0;
      step("sw_decode", e, en_mask());
      step("sw_memadr", e, en_mask());
      bus.mem_ready = 1'b0;
      @(negedge clk);
      e = '0; e.iord = 1'b1; e.mem_we = 1'b1;
      chk("sw_memwr", e, en_mask());
      rst_n = 1'b0;
      #1;
      chk("reset_mid_memwr", '0, '1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      e = '0; e.op = 4'b0010; e.sb = 2'd1; e.mem_rd = 1'b1;
      m = en_mask(); m.op = '1; m.sb = '1; m.iord = 1'b1;
      step("post_reset_fetch", e, m);

      for (int k = 0; k < 200; k++) begin
         logic [5:0] op;
         op = op_tab[$urandom_range(0, 7)];
         if (op == 6'b111111) op = 6'($urandom);
         if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
         else fn = valid_fn[$urandom_range(0, 9)];
         run_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
